// File: rtl/dmem_responder.sv
// Data-memory responder: one valid/ready request at a time, RISC-V sized
// little-endian access into internal storage after a programmable wait.
module dmem_responder #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned Depth = 2 ** (ADDR_W - 2);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                latch, commit;

   logic                we_q;
   logic [2:0]          funct3_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;

   logic                rsp_valid_q;
   logic [31:0]         rsp_rdata_q;
   logic                rsp_err_q;

   logic [31:0]         mem [Depth];

   logic [ADDR_W-3:0]   word_idx;
   logic [1:0]          lane;
   logic [31:0]         rd_word;
   logic [15:0]         lane_data;
   logic                illegal, misaligned, acc_err;
   logic [31:0]         load_data;
   logic [31:0]         wr_word;

   assign req_ready = (state_q == StIdle) && !rst;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // Next-state logic for the IDLE -> WAIT -> RESP handshake sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               latch   = 1'b1;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               commit  = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Decode the latched request: error check, load extraction, store merge.
   always_comb begin
      word_idx  = addr_q[ADDR_W-1:2];
      lane      = addr_q[1:0];
      rd_word   = mem[word_idx];
      lane_data = 16'(rd_word >> {lane, 3'b000});

      if (we_q) illegal = (funct3_q != 3'b000) && (funct3_q != 3'b001) && (funct3_q != 3'b010);
      else      illegal = (funct3_q == 3'b011) || (funct3_q == 3'b110) || (funct3_q == 3'b111);
      misaligned = ((funct3_q[1:0] == 2'b01) && lane[0])
                || ((funct3_q[1:0] == 2'b10) && (lane != 2'b00));
      acc_err = illegal || misaligned;

      load_data = 32'd0;
      case (funct3_q)
         3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
         3'b001:  load_data = {{16{lane_data[15]}}, lane_data};
         3'b010:  load_data = rd_word;
         3'b100:  load_data = {24'd0, lane_data[7:0]};
         3'b101:  load_data = {16'd0, lane_data};
         default: load_data = 32'd0;
      endcase

      // Untouched lanes keep their current contents.
      wr_word = rd_word;
      case (funct3_q[1:0])
         2'b00:   wr_word[{lane, 3'b000} +: 8]        = wdata_q[7:0];
         2'b01:   wr_word[{lane[1], 4'b0000} +: 16]   = wdata_q[15:0];
         2'b10:   wr_word                             = wdata_q;
         default: wr_word                             = rd_word;
      endcase
   end

   // State, wait counter and registered response; rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= (acc_err || we_q) ? 32'd0 : load_data;
         end else if ((state_q == StResp) && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
         end
      end
   end

   // Capture the request fields on acceptance.
   always_ff @(posedge clk) begin
      if (latch && !rst) begin
         we_q     <= req_we;
         funct3_q <= req_funct3;
         addr_q   <= req_addr;
         wdata_q  <= req_wdata;
      end
   end

   // Storage write at commit; never cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst && commit && we_q && !acc_err) begin
         mem[word_idx] <= wr_word;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_CYCLES of 1, 0 and 3.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic        req_we     [3];
   logic [2:0]  req_funct3 [3];
   logic [7:0]  req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic        rsp_valid  [3];
   logic        rsp_ready  [3];
   logic [31:0] rsp_rdata  [3];
   logic        rsp_err    [3];

   logic [32:0] sb [$];
   int          total  = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut_w1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );
   dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );
   dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_dut_w3 (
      .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2]),
      .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
      .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive one request, push its expected result, wait for and check the response.
   task automatic issue(input int d, input logic we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input string tag);
      int n;
      logic [32:0] e;
      sb.push_back({exp_err, exp_rd});
      chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
      req_valid[d]  = 1'b1;
      req_we[d]     = we;
      req_funct3[d] = f3;
      req_addr[d]   = addr;
      req_wdata[d]  = wd;
      @(negedge clk);
      req_valid[d] = 1'b0;
      req_wdata[d] = 32'h5A5A_5A5A;
      n = 0;
      while (!rsp_valid[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      e = sb.pop_front();
      chk({tag, "_rdata"}, rsp_rdata[d], e[31:0]);
      chk({tag, "_err"}, 32'(rsp_err[d]), 32'(e[32]));
   endtask

   // Take the pending response and check the return to idle.
   task automatic take(input int d, input string tag);
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      chk({tag, "_cleared"}, {rsp_rdata[d][30:0], rsp_valid[d]}, 32'd0);
      chk({tag, "_err_clr"}, 32'(rsp_err[d]), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'b010;
         req_addr[i] = 8'h00; req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk("ready_low_in_reset", 32'(req_ready[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset_state", {rsp_rdata[i][29:0], rsp_err[i], rsp_valid[i]}, 32'd0);
         chk("reset_ready", 32'(req_ready[i]), 32'd1);
      end

      // 1: word store and load
      issue(0, 1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, "t1_sw");
      take(0, "t1_sw");
      issue(0, 1'b0, 3'b010, 8'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, "t1_lw");
      take(0, "t1_lw");

      // 2: byte store, signed/unsigned byte loads
      issue(0, 1'b1, 3'b000, 8'h11, 32'h0000_0080, 32'd0, 1'b0, 2, "t2_sb");
      take(0, "t2_sb");
      issue(0, 1'b0, 3'b010, 8'h10, 32'd0, 32'hDEAD80EF, 1'b0, 2, "t2_lw");
      take(0, "t2_lw");
      issue(0, 1'b0, 3'b000, 8'h11, 32'd0, 32'hFFFFFF80, 1'b0, 2, "t2_lb");
      take(0, "t2_lb");
      issue(0, 1'b0, 3'b100, 8'h11, 32'd0, 32'h00000080, 1'b0, 2, "t2_lbu");
      take(0, "t2_lbu");

      // 3: misaligned half store is rejected, half loads
      issue(0, 1'b1, 3'b001, 8'h13, 32'h0000_1234, 32'd0, 1'b1, 2, "t3_sh_mis");
      take(0, "t3_sh_mis");
      issue(0, 1'b0, 3'b010, 8'h10, 32'd0, 32'hDEAD80EF, 1'b0, 2, "t3_lw");
      take(0, "t3_lw");
      issue(0, 1'b0, 3'b001, 8'h12, 32'd0, 32'hFFFFDEAD, 1'b0, 2, "t3_lh");
      take(0, "t3_lh");
      issue(0, 1'b0, 3'b101, 8'h12, 32'd0, 32'h0000DEAD, 1'b0, 2, "t3_lhu");
      take(0, "t3_lhu");
      issue(0, 1'b0, 3'b010, 8'h11, 32'd0, 32'd0, 1'b1, 2, "t3_lw_mis");
      take(0, "t3_lw_mis");
      issue(0, 1'b1, 3'b011, 8'h10, 32'hFFFF_FFFF, 32'd0, 1'b1, 2, "t3_st_ill");
      take(0, "t3_st_ill");

      // 4: response held under back-pressure, stray request ignored
      issue(0, 1'b0, 3'b010, 8'h10, 32'd0, 32'hDEAD80EF, 1'b0, 2, "t4_lw");
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
            req_addr[0] = 8'h10; req_wdata[0] = 32'h0BAD_0BAD;
         end else begin
            req_valid[0] = 1'b0;
         end
         @(negedge clk);
         chk("t4_hold_valid", 32'(rsp_valid[0]), 32'd1);
         chk("t4_hold_rdata", rsp_rdata[0], 32'hDEAD80EF);
         chk("t4_hold_err", 32'(rsp_err[0]), 32'd0);
         chk("t4_hold_ready", 32'(req_ready[0]), 32'd0);
      end
      take(0, "t4_lw");
      issue(0, 1'b0, 3'b010, 8'h10, 32'd0, 32'hDEAD80EF, 1'b0, 2, "t4_after");
      take(0, "t4_after");

      // 5: reset during WAIT aborts the store
      issue(0, 1'b1, 3'b010, 8'h20, 32'h11223344, 32'd0, 1'b0, 2, "t5_init");
      take(0, "t5_init");
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
      req_addr[0] = 8'h20; req_wdata[0] = 32'hCAFEF00D;
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5_no_rsp", 32'(rsp_valid[0]), 32'd0);
      end
      chk("t5_idle", 32'(req_ready[0]), 32'd1);
      issue(0, 1'b0, 3'b010, 8'h20, 32'd0, 32'h11223344, 1'b0, 2, "t5_lw");
      take(0, "t5_lw");

      // 6: illegal load funct3 across wait-state settings
      issue(0, 1'b0, 3'b011, 8'h10, 32'd0, 32'd0, 1'b1, 2, "t6_w1");
      take(0, "t6_w1");
      issue(1, 1'b0, 3'b011, 8'h10, 32'd0, 32'd0, 1'b1, 1, "t6_w0");
      take(1, "t6_w0");
      issue(2, 1'b0, 3'b011, 8'h10, 32'd0, 32'd0, 1'b1, 4, "t6_w3");
      take(2, "t6_w3");
      issue(2, 1'b1, 3'b001, 8'h42, 32'h0000_A5C3, 32'd0, 1'b0, 4, "t6_w3_sh");
      take(2, "t6_w3_sh");
      issue(2, 1'b0, 3'b001, 8'h42, 32'd0, 32'hFFFFA5C3, 1'b0, 4, "t6_w3_lh");
      take(2, "t6_w3_lh");

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
